// File: rtl/fnd_scan_controller.sv
// Scan controller for a 4-digit 7-segment display with two 4-position pages.
// All outputs are registered from next-state values, so position, nibble, dp and blank change on the same edge.
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_page,
  input  logic [31:0] i_digits,
  input  logic        i_blink_en,
  output logic [2:0]  o_digitPosition,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_blank,
  output logic        o_frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       d, d_nxt;
  logic             page_q, page_nxt;
  logic [FC_W-1:0]  fc, fc_nxt;
  logic             phase, phase_nxt;
  logic             tick, wrap;
  logic [2:0]       np;
  logic [3:0]       nib;
  logic             blank_nxt, dp_nxt;

  always_comb begin
    tick      = (cnt == CNT_LAST);
    wrap      = tick && (d == 2'd3);
    cnt_nxt   = tick ? '0 : cnt + 1'b1;
    d_nxt     = tick ? d + 2'd1 : d;
    page_nxt  = wrap ? i_page : page_q;
    np        = {page_nxt, d_nxt};
    nib       = i_digits[{np, 2'b00} +: 4];
    // Leading digit shows nothing when zero; non-BCD codes are always blanked.
    blank_nxt = (nib > 4'd9) || ((d_nxt == 2'd3) && (nib == 4'd0));

    fc_nxt    = fc;
    phase_nxt = phase;
    if (!i_blink_en) begin
      fc_nxt    = '0;
      phase_nxt = 1'b1;
    end else if (wrap) begin
      if (fc == FC_LAST) begin
        fc_nxt    = '0;
        phase_nxt = ~phase;
      end else begin
        fc_nxt    = fc + 1'b1;
      end
    end
    dp_nxt = (d_nxt == 2'd2) && phase_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt             <= '0;
      d               <= 2'd0;
      page_q          <= 1'b0;
      fc              <= '0;
      phase           <= 1'b1;
      o_digitPosition <= 3'd0;
      o_bcd           <= 4'd0;
      o_dp            <= 1'b0;
      o_blank         <= 1'b1;
      o_frame_tick    <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      d               <= d_nxt;
      page_q          <= page_nxt;
      fc              <= fc_nxt;
      phase           <= phase_nxt;
      o_digitPosition <= np;
      o_bcd           <= nib;
      o_dp            <= dp_nxt;
      o_blank         <= blank_nxt;
      o_frame_tick    <= wrap;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: a frame-arithmetic model predicts every cycle's outputs.
module tb_fnd_scan_controller;

  localparam int S  = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        page = 1'b0;
  logic [31:0] digits = 32'h8765_4321;
  logic        blink_en = 1'b1;
  logic [2:0]  pos;
  logic [3:0]  bcd;
  logic        dp, blank, ft;

  fnd_scan_controller #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_page(page), .i_digits(digits),
    .i_blink_en(blink_en), .o_digitPosition(pos), .o_bcd(bcd), .o_dp(dp),
    .o_blank(blank), .o_frame_tick(ft)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos; int bcd; int dp; int blank; int ft;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model state: edges since release, latched page, wraps since blink enabled.
  int e = 0;
  int mpage = 0;
  int mwraps = 0;
  int mphase = 1;
  int cur_pos = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; mpage = 0; mwraps = 0; mphase = 1; cur_pos = 0;
    exp_q.delete();
  endtask

  task automatic step();
    exp_t x, y;
    int en_nxt, dd;
    logic [31:0] sh;
    en_nxt = e + 1;
    if (en_nxt % FRAME == 0) mpage = page;
    dd = (en_nxt / S) % 4;
    if (!blink_en) begin
      mwraps = 0; mphase = 1;
    end else if (en_nxt % FRAME == 0) begin
      mwraps++;
      mphase = ((mwraps / BF) % 2 == 0) ? 1 : 0;
    end
    x.pos   = mpage * 4 + dd;
    sh      = digits >> (x.pos * 4);
    x.bcd   = int'(sh[3:0]);
    x.blank = (x.bcd > 9 || (dd == 3 && x.bcd == 0)) ? 1 : 0;
    x.dp    = (dd == 2) ? mphase : 0;
    x.ft    = (en_nxt % FRAME == 0) ? 1 : 0;
    exp_q.push_back(x);
    @(posedge clk);
    e = en_nxt;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      y = exp_q.pop_front();
      chk("pos", int'(pos), y.pos);
      chk("bcd", int'(bcd), y.bcd);
      chk("dp", int'(dp), y.dp);
      chk("blank", int'(blank), y.blank);
      chk("ft", int'(ft), y.ft);
      cur_pos = y.pos;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance to the start of the next dwell at position p.
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (cur_pos == p && n < 64) begin step(); n++; end
    while (cur_pos != p && n < 64) begin step(); n++; end
    if (n >= 64) chk("wait_pos_timeout", cur_pos, p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pos"}, int'(pos), 0);
    chk({tag, "_bcd"}, int'(bcd), 0);
    chk({tag, "_dp"}, int'(dp), 0);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_ft"}, int'(ft), 0);
  endtask

  initial begin
    int seen[$];
    int last, n, p;
    logic [31:0] sh;
    logic [3:0] newnib;

    // Reset and scan order
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(3);
    chk("dwell0_pos", int'(pos), 0);
    step();
    chk("dwell1_pos", int'(pos), 1);
    run(11);
    chk("ft15", int'(ft), 0);
    step();
    chk("ft16", int'(ft), 1);
    chk("wrap_pos", int'(pos), 0);

    // Page switch mid-frame
    wait_pos(1);
    page = 1'b1;
    last = 1;
    n = 0;
    while (seen.size() < 6 && n < 60) begin
      step(); n++;
      if (int'(pos) != last) begin seen.push_back(int'(pos)); last = int'(pos); end
    end
    chk("seq_len", seen.size(), 6);
    for (int i = 0; i < seen.size() && i < 6; i++)
      chk("seq_pos", seen[i], (i < 2) ? i + 2 : i + 2);
    n = 0;
    while (e % FRAME != 6 && n < 40) begin step(); n++; end
    page = 1'b0;
    step();
    page = 1'b1;
    run(2 * FRAME);
    chk("glitch_page", int'(pos[2]), 1);

    // Blanking
    page = 1'b0;
    digits = 32'h8765_0A59;
    run(2 * FRAME);
    wait_pos(0); chk("blank_p0", int'(blank), 0);
    wait_pos(1); chk("blank_p1", int'(blank), 0);
    wait_pos(2); chk("blank_p2", int'(blank), 1);
    wait_pos(3); chk("blank_p3", int'(blank), 1);
    digits = 32'h8765_1A59;
    wait_pos(3); chk("blank_p3_one", int'(blank), 0);

    // Blink
    blink_en = 1'b0;
    wait_pos(2); chk("dp_steady_a", int'(dp), 1);
    wait_pos(0);
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_pos(2);
      chk("dp_blink", int'(dp), ((f / 2) % 2 == 0) ? 1 : 0);
    end
    blink_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_pos(2);
      chk("dp_off_blink", int'(dp), 1);
    end

    // Reset mid-operation at position 6 with one frame counted
    blink_en = 1'b1;
    page = 1'b1;
    n = 0;
    while (!(cur_pos == 6 && (mwraps % BF) == 1) && n < 300) begin step(); n++; end
    chk("reach_p6_fc1", (n < 300) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk);
    #1 chk_reset_outputs("mid_rst_hold");
    page = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(3);
    chk("post_rst_dwell", int'(pos), 0);
    step();
    chk("post_rst_p1", int'(pos), 1);

    // Live update mid-dwell
    n = 0;
    while (e % S != 1 && n < 10) begin step(); n++; end
    p = int'(pos);
    sh = digits >> (p * 4);
    newnib = sh[3:0] ^ 4'h6;
    digits[p*4 +: 4] = newnib;
    step();
    chk("live_bcd", int'(bcd), int'(newnib));
    chk("live_pos", int'(pos), p);
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
